mem_loader: RTL and testbench

Host-side program loader that writes a stream of 16-bit words into the accumulator CPU's 256-word program/data RAM. While the core is held reset it drives the same write port that the MBR uses, and releases the core once a load completes cleanly. It accepts words over a valid/ready stream, writes them to consecutive addresses, and reports completion and errors.

---
 rtl/mem_loader_if.sv | 41 ++++
 rtl/mem_loader.sv | 151 +++++++++++++++
 tb/tb_mem_loader.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_loader_if.sv
// Host-to-loader bundle: load command, payload word stream, RAM write port and status.
// Latency: wiring only, no logic inside.
// Backpressure: the payload stream uses valid/ready; the loader is the ready side.
interface mem_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  // Load command
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   word_count;

  // Payload stream
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;

  // RAM write port, shared with the MBR while the core is held
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  // Core control and status
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              error;
  logic [DATA_W-1:0] checksum;

  // Host side: issues commands and words, observes status
  modport master (
    output start, base_addr, word_count, in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, error, checksum
  );

  // Loader side
  modport slave (
    input  start, base_addr, word_count, in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, error, checksum
  );
endinterface

// File: rtl/mem_loader.sv
// Program loader: streams words into consecutive RAM addresses while holding the CPU in reset.
// Latency: 1 cycle from accepted word to RAM write; word_count+2 cycles from start to release.
// Backpressure: in_ready is high in LOAD/CHECK only; in_valid low simply stalls the load.
// Optional LOADER_CHECKSUM_EN: adds CHECK state expecting a trailing checksum word.
module mem_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  mem_loader_if.slave   lif
);

  // Largest legal word_count is the full RAM depth.
  localparam logic [ADDR_W:0]   MAX_CNT  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CHECK, S_FIN} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FIN} state_t;
`endif

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;      // next RAM address to write
  logic [ADDR_W:0]   rem_q;       // payload words still expected
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              cpu_hold_q;
  logic              error_q;

  logic              cnt_ok;
  logic              last_word;
  logic              hs;

  assign cnt_ok    = (lif.word_count != '0) && (lif.word_count <= MAX_CNT);
  assign last_word = (rem_q == CNT_ONE);
  assign hs        = lif.in_valid && lif.in_ready;

`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;
  logic [DATA_W-1:0] sum_d;

  // Running 16-bit sum including the word currently offered.
  always_comb begin
    sum_d = sum_q + lif.in_data;
  end

  // Checksum accumulator: cleared on a legal start, accumulates every accepted word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q <= '0;
    end else if (state_q == S_IDLE) begin
      if (lif.start && cnt_ok) sum_q <= '0;
    end else if (hs) begin
      sum_q <= sum_d;
    end
  end

  assign lif.checksum = sum_q;
`else
  assign lif.checksum = '0;
`endif

  // Loader FSM with registered write port, hold and error outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b1;
      error_q     <= 1'b0;
    end else begin
      // Write strobe is a single-cycle pulse per accepted payload word.
      mem_we_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (lif.start) begin
            if (cnt_ok) begin
              addr_q     <= lif.base_addr;
              rem_q      <= lif.word_count;
              error_q    <= 1'b0;
              cpu_hold_q <= 1'b1;
              state_q    <= S_LOAD;
            end else begin
              // Bad length: flag it but leave the core's hold state alone.
              error_q <= 1'b1;
            end
          end
        end

        S_LOAD: begin
          if (hs) begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= addr_q;
            mem_wdata_q <= lif.in_data;
            addr_q      <= addr_q + ADDR_ONE;   // wraps at the top of RAM
            rem_q       <= rem_q - CNT_ONE;
            if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
              state_q <= S_CHECK;
`else
              state_q <= S_FIN;
`endif
            end
          end
        end

`ifdef LOADER_CHECKSUM_EN
        S_CHECK: begin
          // Trailing word makes the total sum zero when the image is intact; never written.
          if (hs) begin
            if (sum_d != '0) error_q <= 1'b1;
            state_q <= S_FIN;
          end
        end
`endif

        S_FIN: begin
          // Only a clean load lets the core run.
          if (!error_q) cpu_hold_q <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Handshake and status decode directly from the registered state.
`ifdef LOADER_CHECKSUM_EN
  assign lif.in_ready = (state_q == S_LOAD) || (state_q == S_CHECK);
`else
  assign lif.in_ready = (state_q == S_LOAD);
`endif
  assign lif.busy      = (state_q != S_IDLE);
  assign lif.done      = (state_q == S_FIN);
  assign lif.mem_we    = mem_we_q;
  assign lif.mem_addr  = mem_addr_q;
  assign lif.mem_wdata = mem_wdata_q;
  assign lif.cpu_hold  = cpu_hold_q;
  assign lif.error     = error_q;

endmodule

// File: tb/tb_mem_loader.sv
// Bench for mem_loader: scoreboarded RAM writes plus per-scenario status checks.
// Inputs change 1ns after rising edges; outputs sampled 1ns after edges or on falling edges.
// Optional LOADER_CHECKSUM_EN: loads append a checksum word and extra checksum scenarios run.
module tb_mem_loader;

  logic clk;
  logic rst;

  mem_loader_if #(.ADDR_W(8), .DATA_W(16)) lif ();

  mem_loader #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .lif (lif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Scoreboard of expected writes {addr, data}
  logic [23:0] sb_q[$];
  logic [7:0]  exp_addr;
  logic [15:0] exp_sum;
  int          cyc      = 0;
  int          wr_cnt   = 0;
  int          wr_first = 0;
  int          wr_last  = 0;

  // Write monitor: every observed write must match the head of the scoreboard.
  always @(negedge clk) begin
    logic [23:0] exp;
    cyc++;
    if (lif.mem_we === 1'b1) begin
      wr_cnt++;
      if (wr_cnt == 1) wr_first = cyc;
      wr_last = cyc;
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write got addr=%h data=%h, expected no write", lif.mem_addr, lif.mem_wdata);
      end else begin
        exp = sb_q.pop_front();
        if ({lif.mem_addr, lif.mem_wdata} !== exp) begin
          bad++;
          $display("FAIL write_data got addr=%h data=%h, expected addr=%h data=%h",
                   lif.mem_addr, lif.mem_wdata, exp[23:16], exp[15:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic clr_wr();
    wr_cnt = 0; wr_first = 0; wr_last = 0;
  endtask

  task automatic do_start(input logic [7:0] b, input logic [8:0] n);
    lif.start = 1'b1; lif.base_addr = b; lif.word_count = n;
    exp_addr = b; exp_sum = 16'h0;
    @(posedge clk); #1;
    lif.start = 1'b0;
  endtask

  task automatic push_word(input logic [15:0] d);
    lif.in_valid = 1'b1; lif.in_data = d;
    sb_q.push_back({exp_addr, d});
    exp_addr = exp_addr + 8'd1;
    exp_sum  = exp_sum + d;
    @(posedge clk); #1;
    lif.in_valid = 1'b0;
  endtask

  // Supplies the trailing checksum word when the feature is built in.
  task automatic finish_load();
`ifdef LOADER_CHECKSUM_EN
    lif.in_valid = 1'b1; lif.in_data = 16'h0 - exp_sum;
    @(posedge clk); #1;
    lif.in_valid = 1'b0;
`endif
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    lif.start = 0; lif.base_addr = 0; lif.word_count = 0; lif.in_valid = 0; lif.in_data = 0;
    #2 rst = 1'b0;
    #1;
    total++; if (lif.in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got %b want 0", lif.in_ready); end
    total++; if (lif.mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we got %b want 0", lif.mem_we); end
    total++; if ({lif.mem_addr, lif.mem_wdata} !== 24'h0) begin bad++; $display("FAIL rst_mem_bus got %h want 0", {lif.mem_addr, lif.mem_wdata}); end
    total++; if (lif.cpu_hold !== 1'b1) begin bad++; $display("FAIL rst_cpu_hold got %b want 1", lif.cpu_hold); end
    total++; if ({lif.busy, lif.done, lif.error} !== 3'b000) begin bad++; $display("FAIL rst_status got %b want 000", {lif.busy, lif.done, lif.error}); end
    total++; if (lif.checksum !== 16'h0) begin bad++; $display("FAIL rst_checksum got %h want 0", lif.checksum); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    clr_wr();
    do_start(8'h10, 9'd3);
    total++; if ({lif.busy, lif.in_ready, lif.cpu_hold} !== 3'b111) begin bad++; $display("FAIL basic_load_entry got %b want 111", {lif.busy, lif.in_ready, lif.cpu_hold}); end
    push_word(16'h1111);
    push_word(16'h2222);
    push_word(16'h3333);
    finish_load();
    total++; if (lif.done !== 1'b1) begin bad++; $display("FAIL basic_done got %b want 1", lif.done); end
    total++; if (lif.cpu_hold !== 1'b1) begin bad++; $display("FAIL basic_hold_in_fin got %b want 1", lif.cpu_hold); end
    @(posedge clk); #1;
    total++; if ({lif.done, lif.busy, lif.cpu_hold, lif.error} !== 4'b0000) begin bad++; $display("FAIL basic_release got %b want 0000", {lif.done, lif.busy, lif.cpu_hold, lif.error}); end
    total++; if (lif.checksum !== 16'h0) begin bad++; $display("FAIL basic_checksum got %h want 0", lif.checksum); end
    total++; if (wr_cnt !== 3 || (wr_last - wr_first) !== 2) begin bad++; $display("FAIL basic_b2b got writes=%0d span=%0d want 3/2", wr_cnt, wr_last - wr_first); end
    total++; if (sb_q.size() !== 0) begin bad++; $display("FAIL basic_sb_left got %0d want 0", sb_q.size()); end
  endtask

  task automatic test_wrap();
    clr_wr();
    do_start(8'hFE, 9'd3);
    push_word(16'hA0A0);
    push_word(16'hB1B1);
    push_word(16'hC2C2);
    finish_load();
    @(posedge clk); #1;
    total++; if (lif.cpu_hold !== 1'b0) begin bad++; $display("FAIL wrap_release got %b want 0", lif.cpu_hold); end
    total++; if (wr_cnt !== 3 || sb_q.size() !== 0) begin bad++; $display("FAIL wrap_writes got %0d left=%0d want 3/0", wr_cnt, sb_q.size()); end
  endtask

  task automatic test_stall();
    clr_wr();
    do_start(8'h40, 9'd2);
    push_word(16'h4444);
    total++; if (lif.mem_we !== 1'b1) begin bad++; $display("FAIL stall_first_we got %b want 1", lif.mem_we); end
    // Stall two cycles and try to restart mid-load.
    lif.start = 1'b1; lif.base_addr = 8'h80; lif.word_count = 9'd5;
    @(posedge clk); #1;
    lif.start = 1'b0;
    total++; if (lif.mem_we !== 1'b0 || lif.busy !== 1'b1) begin bad++; $display("FAIL stall_cycle1 got we=%b busy=%b want 0/1", lif.mem_we, lif.busy); end
    @(posedge clk); #1;
    total++; if (lif.mem_we !== 1'b0 || lif.in_ready !== 1'b1) begin bad++; $display("FAIL stall_cycle2 got we=%b rdy=%b want 0/1", lif.mem_we, lif.in_ready); end
    push_word(16'h5555);
    finish_load();
    total++; if (lif.done !== 1'b1) begin bad++; $display("FAIL stall_done got %b want 1", lif.done); end
    @(posedge clk); #1;
    total++; if (wr_cnt !== 2 || sb_q.size() !== 0) begin bad++; $display("FAIL stall_writes got %0d left=%0d want 2/0", wr_cnt, sb_q.size()); end
    total++; if (lif.cpu_hold !== 1'b0 || lif.busy !== 1'b0) begin bad++; $display("FAIL stall_release got hold=%b busy=%b want 0/0", lif.cpu_hold, lif.busy); end
  endtask

  task automatic test_illegal();
    clr_wr();
    lif.start = 1'b1; lif.base_addr = 8'h00; lif.word_count = 9'd0;
    @(posedge clk); #1;
    lif.start = 1'b0;
    total++; if ({lif.error, lif.busy, lif.in_ready, lif.cpu_hold} !== 4'b1000) begin bad++; $display("FAIL illegal_zero got %b want 1000", {lif.error, lif.busy, lif.in_ready, lif.cpu_hold}); end
    @(posedge clk); #1;
    lif.start = 1'b1; lif.word_count = 9'd257;
    @(posedge clk); #1;
    lif.start = 1'b0;
    total++; if ({lif.error, lif.busy, lif.in_ready} !== 3'b100) begin bad++; $display("FAIL illegal_257 got %b want 100", {lif.error, lif.busy, lif.in_ready}); end
    do_start(8'h20, 9'd1);
    total++; if ({lif.error, lif.cpu_hold, lif.busy} !== 3'b011) begin bad++; $display("FAIL illegal_clear got %b want 011", {lif.error, lif.cpu_hold, lif.busy}); end
    push_word(16'h7777);
    finish_load();
    @(posedge clk); #1;
    total++; if ({lif.cpu_hold, lif.error} !== 2'b00 || wr_cnt !== 1) begin bad++; $display("FAIL illegal_recover got %b writes=%0d want 00/1", {lif.cpu_hold, lif.error}, wr_cnt); end
  endtask

  task automatic test_reset_mid_load();
    clr_wr();
    do_start(8'h30, 9'd4);
    push_word(16'h0A0A);
    push_word(16'h0B0B);
    lif.in_valid = 1'b1; lif.in_data = 16'h0C0C;
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    total++; if ({lif.in_ready, lif.mem_we, lif.cpu_hold, lif.busy} !== 4'b0010) begin bad++; $display("FAIL midrst_async got %b want 0010", {lif.in_ready, lif.mem_we, lif.cpu_hold, lif.busy}); end
    total++; if ({lif.mem_addr, lif.mem_wdata, lif.done, lif.error} !== 26'h0) begin bad++; $display("FAIL midrst_outputs got %h want 0", {lif.mem_addr, lif.mem_wdata, lif.done, lif.error}); end
    lif.in_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    total++; if (wr_cnt !== 2 || sb_q.size() !== 0 || lif.busy !== 1'b0) begin bad++; $display("FAIL midrst_after got writes=%0d left=%0d busy=%b want 2/0/0", wr_cnt, sb_q.size(), lif.busy); end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    clr_wr();
    do_start(8'h50, 9'd2);
    push_word(16'h0001);
    push_word(16'h0002);
    lif.in_valid = 1'b1; lif.in_data = 16'hFFFD;
    @(posedge clk); #1;
    lif.in_valid = 1'b0;
    total++; if ({lif.done, lif.error, lif.mem_we} !== 3'b100) begin bad++; $display("FAIL cks_good_fin got %b want 100", {lif.done, lif.error, lif.mem_we}); end
    @(posedge clk); #1;
    total++; if ({lif.cpu_hold, lif.error} !== 2'b00 || lif.checksum !== 16'h0) begin bad++; $display("FAIL cks_good got hold=%b err=%b sum=%h want 0/0/0000", lif.cpu_hold, lif.error, lif.checksum); end

    do_start(8'h50, 9'd2);
    push_word(16'h0001);
    push_word(16'h0002);
    lif.in_valid = 1'b1; lif.in_data = 16'hFFFC;
    @(posedge clk); #1;
    lif.in_valid = 1'b0;
    total++; if ({lif.done, lif.error} !== 2'b11) begin bad++; $display("FAIL cks_bad_fin got %b want 11", {lif.done, lif.error}); end
    @(posedge clk); #1;
    total++; if ({lif.cpu_hold, lif.error, lif.done} !== 3'b110 || lif.checksum !== 16'hFFFF) begin bad++; $display("FAIL cks_bad got hold=%b err=%b done=%b sum=%h want 1/1/0/ffff", lif.cpu_hold, lif.error, lif.done, lif.checksum); end
    total++; if (wr_cnt !== 4 || sb_q.size() !== 0) begin bad++; $display("FAIL cks_writes got %0d left=%0d want 4/0", wr_cnt, sb_q.size()); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_illegal();
    test_reset_mid_load();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
